// File: rtl/back_ground_pattern_gen_if.sv
// Pixel-coordinate / mode-control bundle between the VGA controller and the background generator.
interface back_ground_pattern_gen_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [1:0]  modeReq;
    logic        modeLoad;
    logic        scrollEn;
    logic [7:0]  BG_RGB;
    logic        boardersDrawReq;
    logic [1:0]  activeMode;

    modport master (
        output pixelX, pixelY, startOfFrame, modeReq, modeLoad, scrollEn,
        input  BG_RGB, boardersDrawReq, activeMode
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, modeReq, modeLoad, scrollEn,
        output BG_RGB, boardersDrawReq, activeMode
    );
endinterface

// File: rtl/back_ground_pattern_gen.sv
// Background generator: four draw modes, border band, per-frame horizontal scroll,
// and mode changes that are deferred to the next frame boundary.
module back_ground_pattern_gen #(
    parameter int unsigned X_FRAME_SIZE  = 639,
    parameter int unsigned Y_FRAME_SIZE  = 479,
    parameter int unsigned BORDER_OFFSET = 1,
    parameter int unsigned BORDER_WIDTH  = 1,
    parameter int unsigned TILE_LOG2     = 5,
    parameter int unsigned SCROLL_STEP   = 1,
    parameter logic [7:0]  BASE_COLOR    = 8'hE4,
    parameter logic [7:0]  ALT_COLOR     = 8'h1F,
    parameter logic [7:0]  BORDER_COLOR  = 8'hFC
) (
    input  logic                       clk,
    input  logic                       resetN,
    back_ground_pattern_gen_if.slave   bus
);

    localparam int unsigned COORD_W = 11;
    localparam int unsigned SUM_W   = 12;

    localparam logic [SUM_W-1:0]   X_SPAN = SUM_W'(X_FRAME_SIZE + 1);
    localparam logic [SUM_W-1:0]   STEP   = SUM_W'(SCROLL_STEP);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X_FRAME_SIZE);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(Y_FRAME_SIZE);

    // Band bounds: near edge [LO0, LO1], far edge [HI0, HI1]
    localparam logic [COORD_W-1:0] X_LO0 = COORD_W'(BORDER_OFFSET);
    localparam logic [COORD_W-1:0] X_LO1 = COORD_W'(BORDER_OFFSET + BORDER_WIDTH - 1);
    localparam logic [COORD_W-1:0] X_HI0 = COORD_W'(X_FRAME_SIZE - BORDER_OFFSET - BORDER_WIDTH + 1);
    localparam logic [COORD_W-1:0] X_HI1 = COORD_W'(X_FRAME_SIZE - BORDER_OFFSET);
    localparam logic [COORD_W-1:0] Y_LO0 = COORD_W'(BORDER_OFFSET);
    localparam logic [COORD_W-1:0] Y_LO1 = COORD_W'(BORDER_OFFSET + BORDER_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_HI0 = COORD_W'(Y_FRAME_SIZE - BORDER_OFFSET - BORDER_WIDTH + 1);
    localparam logic [COORD_W-1:0] Y_HI1 = COORD_W'(Y_FRAME_SIZE - BORDER_OFFSET);

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_FRAMED   = 2'd3
    } mode_e;

    mode_e               active_mode;
    mode_e               pending_mode;
    logic                pending_valid;
    logic [COORD_W-1:0]  scroll_x;
    logic [7:0]          bg_rgb;
    logic                border_req;

    logic [SUM_W-1:0]    scroll_sum;
    logic [COORD_W-1:0]  scroll_next;
    logic [SUM_W-1:0]    eff_sum;
    logic [COORD_W-1:0]  eff_x;
    logic                in_band;
    logic                off_screen;
    logic                checker_bit;
    logic [7:0]          color_next;
    logic                req_next;

    // Scroll advance and scrolled column, both wrapped by a single conditional subtract
    always_comb begin
        scroll_sum  = {1'b0, scroll_x} + STEP;
        scroll_next = (scroll_sum >= X_SPAN) ? COORD_W'(scroll_sum - X_SPAN)
                                             : COORD_W'(scroll_sum);
        eff_sum     = {1'b0, bus.pixelX} + {1'b0, scroll_x};
        eff_x       = (eff_sum >= X_SPAN) ? COORD_W'(eff_sum - X_SPAN)
                                          : COORD_W'(eff_sum);
    end

    // Pixel classification and colour selection for the coordinate presented this cycle
    always_comb begin
        off_screen  = (bus.pixelX > X_LAST) || (bus.pixelY > Y_LAST);
        in_band     = ((bus.pixelX >= X_LO0) && (bus.pixelX <= X_LO1)) ||
                      ((bus.pixelX >= X_HI0) && (bus.pixelX <= X_HI1)) ||
                      ((bus.pixelY >= Y_LO0) && (bus.pixelY <= Y_LO1)) ||
                      ((bus.pixelY >= Y_HI0) && (bus.pixelY <= Y_HI1));
        checker_bit = eff_x[TILE_LOG2] ^ bus.pixelY[TILE_LOG2];
        color_next  = BASE_COLOR;
        req_next    = 1'b0;
        unique case (active_mode)
            MODE_SOLID:    color_next = BASE_COLOR;
            MODE_CHECKER:  color_next = checker_bit ? ALT_COLOR : BASE_COLOR;
            MODE_GRADIENT: color_next = {BASE_COLOR[7:5], bus.pixelY[8:6], BASE_COLOR[1:0]};
            MODE_FRAMED:   color_next = in_band ? BORDER_COLOR : BASE_COLOR;
            default:       color_next = BASE_COLOR;
        endcase
        if (off_screen) begin
            color_next = 8'h00;
        end else begin
            req_next   = in_band;
        end
    end

    // Frame-synchronous mode commit; a load in the commit cycle stays pending
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            active_mode   <= MODE_SOLID;
            pending_mode  <= MODE_SOLID;
            pending_valid <= 1'b0;
        end else begin
            if (bus.startOfFrame && pending_valid) begin
                active_mode   <= pending_mode;
                pending_valid <= 1'b0;
            end
            if (bus.modeLoad) begin
                pending_mode  <= mode_e'(bus.modeReq);
                pending_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            scroll_x <= '0;
        end else if (bus.startOfFrame && bus.scrollEn) begin
            scroll_x <= scroll_next;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bg_rgb     <= 8'hFF;
            border_req <= 1'b0;
        end else begin
            bg_rgb     <= color_next;
            border_req <= req_next;
        end
    end

    assign bus.BG_RGB          = bg_rgb;
    assign bus.boardersDrawReq = border_req;
    assign bus.activeMode      = active_mode;

endmodule

// File: tb/tb_back_ground_pattern_gen.sv
// Scoreboard bench for back_ground_pattern_gen: expected pixels queued at drive time,
// compared one clock later by a monitor.
module tb_back_ground_pattern_gen;

    localparam int XFS = 639;
    localparam int YFS = 479;
    localparam int BO  = 1;
    localparam int BW  = 1;

    typedef struct packed {
        logic [7:0] rgb;
        logic       req;
    } exp_t;

    logic clk;
    logic resetN;
    logic drv_v;

    back_ground_pattern_gen_if bus ();

    back_ground_pattern_gen dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    exp_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;

    int    m_mode, m_pend, m_scroll;
    logic  m_pv;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [8:0] model(input int x, input int y, input int mode, input int scroll);
        logic       band;
        logic [7:0] c;
        int         ex;
        if (x > XFS || y > YFS) return 9'h000;
        band = (x >= BO && x <= BO + BW - 1) || (x >= XFS - BO - BW + 1 && x <= XFS - BO) ||
               (y >= BO && y <= BO + BW - 1) || (y >= YFS - BO - BW + 1 && y <= YFS - BO);
        ex = (x + scroll) % (XFS + 1);
        case (mode)
            0:       c = 8'hE4;
            1:       c = ((((ex >> 5) ^ (y >> 5)) & 1) != 0) ? 8'h1F : 8'hE4;
            2:       c = {3'b111, 3'(y >> 6), 2'b00};
            default: c = band ? 8'hFC : 8'hE4;
        endcase
        return {band, c};
    endfunction

    // Bench-side model of the mode/scroll registers
    task automatic m_event(input logic sof, input logic ld, input int rq);
        if (sof) begin
            if (m_pv) begin
                m_mode = m_pend;
                m_pv   = 1'b0;
            end
            if (bus.scrollEn) m_scroll = (m_scroll + 1) % (XFS + 1);
        end
        if (ld) begin
            m_pend = rq;
            m_pv   = 1'b1;
        end
    endtask

    task automatic send(input int x, input int y, input logic [7:0] rgb, input logic req,
                        input string tag, input logic sof = 1'b0);
        exp_t e;
        @(negedge clk);
        bus.pixelX       = 11'(x);
        bus.pixelY       = 11'(y);
        bus.startOfFrame = sof;
        bus.modeLoad     = 1'b0;
        drv_v            = 1'b1;
        e.rgb = rgb;
        e.req = req;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        m_event(sof, 1'b0, 0);
    endtask

    task automatic send_rand(input int n, input string tag);
        logic [8:0] r;
        int x, y;
        for (int i = 0; i < n; i++) begin
            x = $urandom_range(0, 700);
            y = $urandom_range(0, 520);
            r = model(x, y, m_mode, m_scroll);
            send(x, y, r[7:0], r[8], tag);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        bus.modeLoad     = 1'b0;
        drv_v            = 1'b0;
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.startOfFrame = 1'b1;
            bus.modeLoad     = 1'b0;
            drv_v            = 1'b0;
            m_event(1'b1, 1'b0, 0);
        end
    endtask

    task automatic load(input int m, input logic sof);
        @(negedge clk);
        bus.modeReq      = 2'(m);
        bus.modeLoad     = 1'b1;
        bus.startOfFrame = sof;
        drv_v            = 1'b0;
        m_event(sof, 1'b1, m);
    endtask

    // Monitor: pixel driven before this edge is checked shortly after it
    logic  mon_v;
    exp_t  mon_e;
    string mon_tag;
    always @(posedge clk) begin
        mon_v = drv_v && resetN;
        #2;
        if (mon_v) begin
            if (exp_q.size() == 0) begin
                check("q_underflow", 16'd1, 16'd0);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                check({mon_tag, "_rgb"}, 16'(bus.BG_RGB), 16'(mon_e.rgb));
                check({mon_tag, "_req"}, 16'(bus.boardersDrawReq), 16'(mon_e.req));
            end
        end
    end

    initial begin
        clk = 1'b0;
        resetN = 1'b0;
        drv_v = 1'b0;
        bus.pixelX = '0;
        bus.pixelY = '0;
        bus.startOfFrame = 1'b0;
        bus.modeReq = '0;
        bus.modeLoad = 1'b0;
        bus.scrollEn = 1'b0;
        m_mode = 0; m_pend = 0; m_pv = 1'b0; m_scroll = 0;

        #12;
        check("rst_rgb",  16'(bus.BG_RGB), 16'hFF);
        check("rst_req",  16'(bus.boardersDrawReq), 16'h0);
        check("rst_mode", 16'(bus.activeMode), 16'h0);
        @(negedge clk);
        resetN = 1'b1;

        send(100, 100, 8'hE4, 1'b0, "solid");
        send(1,   200, 8'hE4, 1'b1, "band_x_lo");
        send(0,   200, 8'hE4, 1'b0, "edge_x0");
        send(638, 5,   8'hE4, 1'b1, "band_x_hi");
        send(637, 5,   8'hE4, 1'b0, "inner_x");
        send(300, 478, 8'hE4, 1'b1, "band_y_hi");
        send(640, 10,  8'h00, 1'b0, "off_x");
        send(10,  480, 8'h00, 1'b0, "off_y");
        send_rand(8, "rnd_solid");

        // Mode commit deferred to frame boundary; pixel in the pulse cycle uses old mode
        load(1, 1'b0);
        idle();
        check("mode_pending", 16'(bus.activeMode), 16'd0);
        send(32, 0, 8'hE4, 1'b0, "old_mode_at_sof", 1'b1);
        send(32, 0, 8'h1F, 1'b0, "chk_32_0");
        check("mode_commit", 16'(bus.activeMode), 16'd1);
        send(0,  0,  8'hE4, 1'b0, "chk_0_0");
        send(32, 32, 8'hE4, 1'b0, "chk_32_32");
        send_rand(8, "rnd_chk");

        load(3, 1'b0);
        frame(1);
        send(1,   1,   8'hFC, 1'b1, "framed_1_1");
        send(100, 100, 8'hE4, 1'b0, "framed_in");
        send_rand(8, "rnd_framed");

        // Scroll in CHECKER
        load(1, 1'b0);
        frame(1);
        idle();
        bus.scrollEn = 1'b1;
        frame(32);
        idle();
        bus.scrollEn = 1'b0;
        send(0, 0, 8'h1F, 1'b0, "scroll32_0_0");
        send_rand(12, "rnd_scroll");
        bus.scrollEn = 1'b1;
        frame(608);
        idle();
        bus.scrollEn = 1'b0;
        send(0,  0, 8'hE4, 1'b0, "scroll_wrap_0_0");
        send(32, 0, 8'h1F, 1'b0, "scroll_wrap_32_0");

        // Load in the same cycle as the frame pulse stays pending
        load(2, 1'b1);
        idle();
        check("simul_hold", 16'(bus.activeMode), 16'd1);
        frame(1);
        idle();
        check("simul_commit", 16'(bus.activeMode), 16'd2);
        send(10, 64,  8'hE4, 1'b0, "grad_64");
        send(10, 448, 8'hFC, 1'b0, "grad_448");
        send_rand(8, "rnd_grad");

        // Asynchronous reset mid-frame in CHECKER with scroll 32
        load(1, 1'b0);
        bus.scrollEn = 1'b1;
        frame(32);
        idle();
        bus.scrollEn = 1'b0;
        send(0, 0, 8'h1F, 1'b0, "pre_rst_0_0");
        idle();
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        check("mid_rst_rgb",  16'(bus.BG_RGB), 16'hFF);
        check("mid_rst_req",  16'(bus.boardersDrawReq), 16'h0);
        check("mid_rst_mode", 16'(bus.activeMode), 16'h0);
        @(negedge clk);
        resetN = 1'b1;
        m_mode = 0; m_pend = 0; m_pv = 1'b0; m_scroll = 0;
        send(32, 0, 8'hE4, 1'b0, "post_rst_solid");
        check("post_rst_mode", 16'(bus.activeMode), 16'd0);
        load(1, 1'b0);
        frame(1);
        send(0,  0, 8'hE4, 1'b0, "post_rst_chk_0_0");
        send(32, 0, 8'h1F, 1'b0, "post_rst_chk_32_0");
        idle();
        idle();
        check("q_empty", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
